// File: rtl/bgp_seq_pkg.sv
// Shared encodings and helpers for the bandgap enable sequencer.
package bgp_seq_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned RETRY_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF      = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_CHECK    = 3'd2,
    ST_READY    = 3'd3,
    ST_COOLDOWN = 3'd4,
    ST_FAULT    = 3'd5
  } state_e;

  typedef struct packed {
    logic bgp_en;
    logic ready;
    logic fault;
  } outs_t;

  // Output pattern for each state; illegal encodings drive everything low.
  function automatic outs_t decode_outs(input state_e s);
    outs_t o;
    o = '0;
    case (s)
      ST_SETTLE, ST_CHECK: o.bgp_en = 1'b1;
      ST_READY: begin
        o.bgp_en = 1'b1;
        o.ready  = 1'b1;
      end
      ST_FAULT: o.fault = 1'b1;
      default:  o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/bgp_sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the clock domain.
module bgp_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/bgp_enable_sequencer.sv
// Bandgap power-up sequencer: enable, settle, qualify via comparator, retry
// a bounded number of times and latch a fault on persistent failure.
module bgp_enable_sequencer
  import bgp_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES   = 64,
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 256,
  parameter int unsigned MAX_RETRIES     = 3,
  parameter int unsigned CNT_W           = 10
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               req_i,
  input  logic               clear_fault_i,
  input  logic               vbgp_ok_i,
  output logic               bgp_en_o,
  output logic               ready_o,
  output logic               fault_o,
  output logic [STATE_W-1:0] state_o,
  output logic [RETRY_W-1:0] retry_cnt_o
);

  localparam logic [CNT_W-1:0]   SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0]   DEB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   deb_q, deb_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  outs_t              outs_q, outs_d;
  logic [CNT_W-1:0]   cnt_inc, deb_inc;
  logic [RETRY_W-1:0] retry_inc;
  logic               ok_s;

  bgp_sync2 u_ok_sync (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .d_i (vbgp_ok_i),
    .q_o (ok_s)
  );

  // State, counters and decoded outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      deb_q   <= '0;
      retry_q <= '0;
      outs_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
      retry_q <= retry_d;
      outs_q  <= outs_d;
    end
  end

  // Saturating increments so no counter can wrap.
  always_comb begin
    cnt_inc   = (&cnt_q)   ? cnt_q   : cnt_q   + CNT_W'(1);
    deb_inc   = (&deb_q)   ? deb_q   : deb_q   + CNT_W'(1);
    retry_inc = (&retry_q) ? retry_q : retry_q + RETRY_W'(1);
  end

  // Next state; a dropped request outranks every completion except in FAULT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    deb_d   = deb_q;
    retry_d = retry_q;
    case (state_q)
      ST_OFF: begin
        cnt_d   = '0;
        deb_d   = '0;
        retry_d = '0;
        if (req_i) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!req_i) begin
          state_d = ST_OFF;
          cnt_d   = '0;
          deb_d   = '0;
          retry_d = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
          cnt_d   = '0;
          deb_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_CHECK: begin
        if (!req_i) begin
          state_d = ST_OFF;
          cnt_d   = '0;
          deb_d   = '0;
          retry_d = '0;
        end else if (ok_s && deb_q == DEB_LAST) begin
          state_d = ST_READY;
          cnt_d   = '0;
          deb_d   = '0;
          retry_d = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d = '0;
          deb_d = '0;
          if (retry_q < RETRY_MAX) begin
            state_d = ST_COOLDOWN;
            retry_d = retry_inc;
          end else begin
            state_d = ST_FAULT;
          end
        end else begin
          cnt_d = cnt_inc;
          deb_d = ok_s ? deb_inc : '0;
        end
      end
      ST_READY: begin
        if (!req_i) begin
          state_d = ST_OFF;
          cnt_d   = '0;
          deb_d   = '0;
          retry_d = '0;
        end else if (!ok_s && deb_q == DEB_LAST) begin
          state_d = ST_COOLDOWN;
          cnt_d   = '0;
          deb_d   = '0;
          retry_d = '0;
        end else begin
          deb_d = ok_s ? '0 : deb_inc;
        end
      end
      ST_COOLDOWN: begin
        if (!req_i) begin
          state_d = ST_OFF;
          cnt_d   = '0;
          deb_d   = '0;
          retry_d = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
          deb_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_FAULT: begin
        cnt_d = '0;
        deb_d = '0;
        if (clear_fault_i) begin
          state_d = ST_OFF;
          retry_d = '0;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
        deb_d   = '0;
        retry_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    outs_d = decode_outs(state_d);
  end

  assign bgp_en_o    = outs_q.bgp_en;
  assign ready_o     = outs_q.ready;
  assign fault_o     = outs_q.fault;
  assign state_o     = state_q;
  assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_bgp_enable_sequencer.sv
// Scoreboard bench: stimulus queues each expected output change with its cycle,
// a monitor pops and compares whenever the DUT outputs change.
module tb_bgp_enable_sequencer;

  localparam logic [2:0] S_OFF = 3'd0;
  localparam logic [2:0] S_SET = 3'd1;
  localparam logic [2:0] S_CHK = 3'd2;
  localparam logic [2:0] S_RDY = 3'd3;
  localparam logic [2:0] S_CD  = 3'd4;
  localparam logic [2:0] S_FLT = 3'd5;

  typedef struct {
    int         t;
    logic [8:0] v;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req = 1'b0;
  logic       clr = 1'b0;
  logic       ok  = 1'b0;
  logic       bgp_en_o, ready_o, fault_o;
  logic [2:0] state_o;
  logic [1:0] retry_cnt_o;
  int         cyc = 0;
  bit         done = 1'b0;
  int         n_assert = 0;
  int         n_fail = 0;
  exp_t       exp_q[$];

  bgp_enable_sequencer #(
    .SETTLE_CYCLES   (4),
    .DEBOUNCE_CYCLES (3),
    .TIMEOUT_CYCLES  (16),
    .MAX_RETRIES     (2),
    .CNT_W           (10)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .req_i         (req),
    .clear_fault_i (clr),
    .vbgp_ok_i     (ok),
    .bgp_en_o      (bgp_en_o),
    .ready_o       (ready_o),
    .fault_o       (fault_o),
    .state_o       (state_o),
    .retry_cnt_o   (retry_cnt_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // t < 0 means the cycle of the change is not checked.
  task automatic expect_ev(input string name, input int t, input logic [2:0] st,
                           input logic en, input logic rdy, input logic flt,
                           input logic [1:0] rt);
    exp_t e;
    e.t    = t;
    e.v    = {st, en, rdy, flt, rt};
    e.name = name;
    exp_q.push_back(e);
  endtask

  initial begin : stimulus
    int b;
    rst = 1'b1;
    expect_ev("reset_state", -1, S_OFF, 0, 0, 0, 2'd0);
    tick(3);
    rst = 1'b0;
    tick(2);

    // Clean start.
    ok = 1'b1;
    tick(3);
    b = cyc;
    req = 1'b1;
    expect_ev("clean_settle", b + 1, S_SET, 1, 0, 0, 2'd0);
    expect_ev("clean_check",  b + 5, S_CHK, 1, 0, 0, 2'd0);
    expect_ev("clean_ready",  b + 8, S_RDY, 1, 1, 0, 2'd0);
    tick(10);

    // Two-cycle glitch is ignored.
    ok = 1'b0;
    tick(2);
    ok = 1'b1;
    tick(6);

    // Three-cycle loss drops to cooldown, then re-qualifies.
    b = cyc;
    ok = 1'b0;
    expect_ev("loss_cooldown", b + 5,  S_CD,  0, 0, 0, 2'd0);
    expect_ev("loss_settle",   b + 9,  S_SET, 1, 0, 0, 2'd0);
    expect_ev("loss_check",    b + 13, S_CHK, 1, 0, 0, 2'd0);
    expect_ev("loss_ready",    b + 16, S_RDY, 1, 1, 0, 2'd0);
    tick(3);
    ok = 1'b1;
    tick(17);

    // Timeout retry then success.
    req = 1'b0;
    expect_ev("drop_ready_off", cyc + 1, S_OFF, 0, 0, 0, 2'd0);
    tick(2);
    ok = 1'b0;
    tick(3);
    b = cyc;
    req = 1'b1;
    expect_ev("retry_settle0", b + 1,  S_SET, 1, 0, 0, 2'd0);
    expect_ev("retry_check0",  b + 5,  S_CHK, 1, 0, 0, 2'd0);
    expect_ev("retry_cd1",     b + 21, S_CD,  0, 0, 0, 2'd1);
    expect_ev("retry_settle1", b + 25, S_SET, 1, 0, 0, 2'd1);
    expect_ev("retry_check1",  b + 29, S_CHK, 1, 0, 0, 2'd1);
    expect_ev("retry_ready",   b + 32, S_RDY, 1, 1, 0, 2'd0);
    tick(22);
    ok = 1'b1;
    tick(15);

    // Persistent failure ends in a sticky fault.
    req = 1'b0;
    expect_ev("drop_ready_off2", cyc + 1, S_OFF, 0, 0, 0, 2'd0);
    ok = 1'b0;
    tick(4);
    b = cyc;
    req = 1'b1;
    expect_ev("fail_settle0", b + 1,  S_SET, 1, 0, 0, 2'd0);
    expect_ev("fail_check0",  b + 5,  S_CHK, 1, 0, 0, 2'd0);
    expect_ev("fail_cd1",     b + 21, S_CD,  0, 0, 0, 2'd1);
    expect_ev("fail_settle1", b + 25, S_SET, 1, 0, 0, 2'd1);
    expect_ev("fail_check1",  b + 29, S_CHK, 1, 0, 0, 2'd1);
    expect_ev("fail_cd2",     b + 45, S_CD,  0, 0, 0, 2'd2);
    expect_ev("fail_settle2", b + 49, S_SET, 1, 0, 0, 2'd2);
    expect_ev("fail_check2",  b + 53, S_CHK, 1, 0, 0, 2'd2);
    expect_ev("fail_fault",   b + 69, S_FLT, 0, 0, 1, 2'd2);
    tick(75);
    req = 1'b0;
    tick(5);
    clr = 1'b1;
    expect_ev("clear_off", cyc + 1, S_OFF, 0, 0, 0, 2'd0);
    tick(1);
    clr = 1'b0;
    tick(3);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(2);

    // Request drop beats debounce completion.
    ok = 1'b1;
    tick(4);
    b = cyc;
    req = 1'b1;
    expect_ev("prio_settle", b + 1, S_SET, 1, 0, 0, 2'd0);
    expect_ev("prio_check",  b + 5, S_CHK, 1, 0, 0, 2'd0);
    expect_ev("prio_off",    b + 8, S_OFF, 0, 0, 0, 2'd0);
    tick(7);
    req = 1'b0;
    tick(3);

    // Request drop mid-settle.
    b = cyc;
    req = 1'b1;
    expect_ev("midset_settle", b + 1, S_SET, 1, 0, 0, 2'd0);
    expect_ev("midset_off",    b + 3, S_OFF, 0, 0, 0, 2'd0);
    tick(2);
    req = 1'b0;
    tick(3);

    // Asynchronous reset mid-check, then restart.
    ok = 1'b0;
    tick(4);
    b = cyc;
    req = 1'b1;
    expect_ev("rst_settle", b + 1, S_SET, 1, 0, 0, 2'd0);
    expect_ev("rst_check",  b + 5, S_CHK, 1, 0, 0, 2'd0);
    tick(7);
    expect_ev("async_reset", cyc, S_OFF, 0, 0, 0, 2'd0);
    rst = 1'b1;
    ok  = 1'b1;
    tick(2);
    rst = 1'b0;
    b = cyc;
    expect_ev("restart_settle", b + 1, S_SET, 1, 0, 0, 2'd0);
    expect_ev("restart_check",  b + 5, S_CHK, 1, 0, 0, 2'd0);
    expect_ev("restart_ready",  b + 8, S_RDY, 1, 1, 0, 2'd0);
    tick(12);
    done = 1'b1;
  end

  initial begin : monitor
    logic [8:0] prev;
    logic [8:0] cur;
    bit         first;
    exp_t       e;
    first = 1'b1;
    prev  = '0;
    while (!done) begin
      @(negedge clk or posedge rst);
      #1;
      cur = {state_o, bgp_en_o, ready_o, fault_o, retry_cnt_o};
      if (first || cur != prev) begin
        first = 1'b0;
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change cyc=%0d got st/en/rdy/flt/rt=%b none expected", cyc, cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e.v || (e.t >= 0 && e.t != cyc)) begin
            n_fail++;
            $display("FAIL %s got %b at cyc %0d, expected %b at cyc %0d",
                     e.name, cur, cyc, e.v, e.t);
          end
        end
      end
      prev = cur;
    end
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events got %0d pending, expected 0 (next %s)",
               exp_q.size(), exp_q[0].name);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bgp_enable_sequencer.md
Name: bgp_enable_sequencer

Overview:
- Digital power-up sequencer directly upstream of the 3.3 V bandgap reference macro.
- Drives the bandgap EN pin and waits a fixed settle time. It then qualifies the bandgap output through an external window-comparator flag (vbgp_ok_i) before reporting ready.
- Failed start-up is retried a bounded number of times, then latched as a fault.
- Sits in the user project between management-SoC control (request/clear) and the analog bandgap macro.

Parameters:
- SETTLE_CYCLES, 64: cycles EN is held before the comparator is checked; also the EN-low cooldown length before a retry.
- DEBOUNCE_CYCLES, 8: consecutive synchronized-ok cycles needed for READY, and consecutive not-ok cycles needed to declare loss in READY.
- TIMEOUT_CYCLES, 256: maximum cycles spent in CHECK per attempt.
- MAX_RETRIES, 3: retries allowed after the first failed attempt before FAULT.
- CNT_W, 10: width of the shared cycle counter; must hold max(SETTLE, DEBOUNCE, TIMEOUT).

Ports:
- wb_clk_i  input  1  system clock.
- wb_rst_i  input  1  reset, asynchronous, active-high.
- req_i  input  1  level request to power the bandgap.
- clear_fault_i  input  1  single-cycle pulse; clears FAULT.
- vbgp_ok_i  input  1  asynchronous window-comparator output (1 = VBGP in range).
- bgp_en_o  output  1  registered drive to the bandgap EN pin.
- ready_o  output  1  bandgap qualified and stable.
- fault_o  output  1  sticky start-up failure.
- state_o  output  3  current FSM state encoding.
- retry_cnt_o  output  2  retries consumed in the current request.

Behaviour:
- Reset (async assert; release on clock edge): state OFF, all counters 0, synchronizer flops 0, every output 0.
- vbgp_ok_i passes through a 2-flop synchronizer (ok_s). All decisions use ok_s only.
- All outputs are registered and decoded from state.
  - bgp_en_o = 1 in SETTLE, CHECK, READY.
  - ready_o = 1 only in READY.
  - fault_o = 1 only in FAULT.
- OFF (0): when req_i = 1, go to SETTLE and clear counter and retries. bgp_en_o is high in the cycle after req_i is sampled high.
- SETTLE (1): lasts exactly SETTLE_CYCLES cycles, then CHECK with counters cleared.
- CHECK (2):
  - Debounce counter increments while ok_s = 1 and resets to 0 when ok_s = 0.
  - After DEBOUNCE_CYCLES consecutive ok cycles: go to READY and clear retries.
  - When the timeout counter has counted TIMEOUT_CYCLES cycles:
    - if retries < MAX_RETRIES: go to COOLDOWN and increment retries;
    - otherwise go to FAULT.
  - If debounce completes in the same cycle as timeout, success wins.
- READY (3): when ok_s = 0 for DEBOUNCE_CYCLES consecutive cycles, go to COOLDOWN with retries reset to 0 and no increment. A shorter glitch is ignored and its counter resets.
- COOLDOWN (4): EN low for exactly SETTLE_CYCLES cycles, then SETTLE.
- FAULT (5):
  - Held regardless of req_i.
  - clear_fault_i = 1 → OFF, retries 0.
  - Only way out besides reset.
- req_i = 0 in SETTLE, CHECK, READY or COOLDOWN → OFF next cycle, counters and retries cleared.
- Priority: req_i drop beats any completing event in the same cycle, except in FAULT.
- clear_fault_i outside FAULT has no effect.
- Counters saturate; no wrap-around.
- Encodings 6 and 7 are illegal and recover to OFF.

Decomposition:
- Shared package/header bgp_seq_pkg holds:
  - state encodings OFF=0, SETTLE=1, CHECK=2, READY=3, COOLDOWN=4, FAULT=5;
  - the state width (3);
  - the retry counter width (2).
- One sub-module, bgp_sync2: a 2-flop synchronizer with async active-high reset to 0, instantiated for vbgp_ok_i.
- FSM and counters stay in the top module.

Test Plan (SETTLE=4, DEBOUNCE=3, TIMEOUT=16, MAX_RETRIES=2, ok held long enough for sync):
- Clean start: ok=1 steady, req_i rises sampled at edge 0 → bgp_en_o=1 from cycle 1, SETTLE cycles 1–4, CHECK 5–7, ready_o=1 at cycle 8, retry_cnt_o=0.
- Timeout retry then success: ok=0 during first CHECK, then 1 → COOLDOWN (en=0 for 4 cycles), retry_cnt_o=1, second attempt reaches READY, retry_cnt_o returns to 0.
- Persistent failure: ok=0 always → three CHECK timeouts with retries 0→1→2, then FAULT. fault_o=1 with req still high and also after req drops; clear_fault_i pulse → OFF, all outputs 0.
- Glitch tolerance: in READY, ok low for 2 cycles → ready_o stays 1. Low for 3 cycles → COOLDOWN, ready_o=0 and bgp_en_o=0 on the next cycle.
- Request drop and priority: req_i drops in the cycle debounce completes → OFF, ready_o never asserts. Also drop req_i mid-SETTLE → OFF next cycle.
- Async reset: assert wb_rst_i mid-CHECK between clock edges → all outputs 0 immediately. After release with req_i=1, the full sequence restarts from SETTLE.
